// File: rtl/id_ex_skid.sv
// id_ex_skid: decode/execute stage register with a valid/ready handshake,
// a one-entry skid buffer, flush-to-NOP and a saturating stall counter.
module id_ex_skid #(
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic                we_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic                we_o,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned PW = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    out_q;
  logic [PW-1:0]    skid_q;
  logic             valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic [PW-1:0]    in_pay;
  logic             in_acc;
  logic             out_acc;

  assign in_pay  = {aluop_i, alusel_i, reg1_i, reg2_i, wr_addr_i, we_i};
  assign in_acc  = valid_i & ready_q;
  assign out_acc = valid_q & ready_i;

  // Occupancy FSM; OUT/SKID payloads are forced to NOP whenever they are empty.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_acc) begin
            state_q <= BUSY;
            out_q   <= in_pay;
            valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_acc && out_acc) begin
            out_q <= in_pay;
          end else if (in_acc) begin
            state_q <= FULL;
            skid_q  <= in_pay;
            ready_q <= 1'b0;
          end else if (out_acc) begin
            state_q <= EMPTY;
            out_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_acc) begin
            state_q <= BUSY;
            out_q   <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          out_q   <= '0;
          skid_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Next stall count: one more per stalled cycle, pinned at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (valid_q && !ready_i && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign stall_cnt = stall_q;
  assign {aluop_o, alusel_o, reg1_o, reg2_o, wr_addr_o, we_o} = out_q;

endmodule

// File: tb/tb_id_ex_skid.sv
module tb_id_ex_skid;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wa;
    logic        we;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic flush = 1'b0;

  // main instance
  logic valid_i = 1'b0, ready_i = 1'b1;
  ins_t in_ins = '0;
  logic ready_o, valid_o, we_o;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0] wr_addr_o;
  logic [15:0] stall_cnt;

  id_ex_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(in_ins.aluop), .alusel_i(in_ins.alusel), .reg1_i(in_ins.r1),
    .reg2_i(in_ins.r2), .wr_addr_i(in_ins.wa), .we_i(in_ins.we),
    .valid_o(valid_o), .ready_i(ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wr_addr_o(wr_addr_o), .we_o(we_o),
    .stall_cnt(stall_cnt)
  );

  // saturation instance (4-bit counter)
  logic s_valid = 1'b0, s_ready = 1'b1;
  logic s_ready_o, s_valid_o, s_we_o;
  logic [7:0] s_aluop_o;
  logic [2:0] s_alusel_o;
  logic [31:0] s_reg1_o, s_reg2_o;
  logic [4:0] s_wr_addr_o;
  logic [3:0] s_cnt;

  id_ex_skid #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0), .valid_i(s_valid), .ready_o(s_ready_o),
    .aluop_i(8'h11), .alusel_i(3'd1), .reg1_i(32'h1), .reg2_i(32'h2),
    .wr_addr_i(5'd1), .we_i(1'b1),
    .valid_o(s_valid_o), .ready_i(s_ready), .aluop_o(s_aluop_o), .alusel_o(s_alusel_o),
    .reg1_o(s_reg1_o), .reg2_o(s_reg2_o), .wr_addr_o(s_wr_addr_o), .we_o(s_we_o),
    .stall_cnt(s_cnt)
  );

  // wide instance
  logic w_valid = 1'b0;
  logic [63:0] w_reg1 = '0, w_reg2 = '0;
  logic [5:0] w_wa = '0;
  logic w_ready_o, w_valid_o, w_we_o;
  logic [7:0] w_aluop_o;
  logic [2:0] w_alusel_o;
  logic [63:0] w_reg1_o, w_reg2_o;
  logic [5:0] w_wr_addr_o;
  logic [15:0] w_cnt;

  id_ex_skid #(.DATA_W(64), .ADDR_W(6)) u_wide (
    .clk(clk), .rst(rst), .flush(1'b0), .valid_i(w_valid), .ready_o(w_ready_o),
    .aluop_i(8'h5A), .alusel_i(3'd4), .reg1_i(w_reg1), .reg2_i(w_reg2),
    .wr_addr_i(w_wa), .we_i(1'b1),
    .valid_o(w_valid_o), .ready_i(1'b1), .aluop_o(w_aluop_o), .alusel_o(w_alusel_o),
    .reg1_o(w_reg1_o), .reg2_o(w_reg2_o), .wr_addr_o(w_wr_addr_o), .we_o(w_we_o),
    .stall_cnt(w_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: an in-order queue of at most two held instructions.
  ins_t mq[$];
  int unsigned m_cnt = 0;
  logic cmp_en = 1'b0;

  always @(posedge clk) begin
    automatic bit m_in  = valid_i && (mq.size() < 2);
    automatic bit m_out = (mq.size() > 0) && ready_i;
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (mq.size() > 0 && !ready_i && m_cnt < 65535) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (m_out) void'(mq.pop_front());
        if (m_in) mq.push_back(in_ins);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic ins_t exp_p = (mq.size() > 0) ? mq[0] : '0;
      automatic ins_t act_p = {aluop_o, alusel_o, reg1_o, reg2_o, wr_addr_o, we_o};
      check("model_valid", {127'd0, valid_o}, {127'd0, mq.size() > 0});
      check("model_ready", {127'd0, ready_o}, {127'd0, mq.size() < 2});
      check("model_payload", {47'd0, act_p}, {47'd0, exp_p});
      check("model_stall", {112'd0, stall_cnt}, {96'd0, m_cnt});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic [31:0] r1, input logic [4:0] wa);
    ins_t t;
    t.aluop = 8'h30 + r1[7:0];
    t.alusel = r1[2:0];
    t.r1 = r1;
    t.r2 = ~r1;
    t.wa = wa;
    t.we = 1'b1;
    return t;
  endfunction

  initial begin
    // reset with junk offered
    rst = 1'b0;
    valid_i = 1'b1;
    in_ins = ins_t'({$urandom, $urandom, $urandom});
    step();
    cmp_en = 1'b1;
    in_ins = ins_t'({$urandom, $urandom, $urandom});
    step();
    check("rst_valid", {127'd0, valid_o}, 128'd0);
    check("rst_we", {127'd0, we_o}, 128'd0);
    check("rst_ready", {127'd0, ready_o}, 128'd1);
    check("rst_stall", {112'd0, stall_cnt}, 128'd0);

    // first instruction, one-cycle latency
    rst = 1'b1;
    ready_i = 1'b1;
    in_ins = '{aluop: 8'h21, alusel: 3'd0, r1: 32'h5, r2: 32'h7, wa: 5'd3, we: 1'b1};
    step();
    check("first_valid", {127'd0, valid_o}, 128'd1);
    check("first_aluop", {120'd0, aluop_o}, 128'h21);
    check("first_reg2", {96'd0, reg2_o}, 128'h7);
    check("first_wa", {123'd0, wr_addr_o}, 128'd3);
    valid_i = 1'b0;
    step();
    check("drain_valid", {127'd0, valid_o}, 128'd0);
    check("drain_we", {127'd0, we_o}, 128'd0);

    // streaming
    valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_ins = mk(i, 5'd1);
      step();
      check("stream_reg1", {96'd0, reg1_o}, 128'(i));
      check("stream_ready", {127'd0, ready_o}, 128'd1);
    end
    valid_i = 1'b0;
    step();
    check("stream_stall", {112'd0, stall_cnt}, 128'd0);

    // backpressure: three stalled cycles with valid_o=1
    ready_i = 1'b0;
    valid_i = 1'b1;
    in_ins = mk(100, 5'd2);
    step();
    in_ins = mk(101, 5'd2);
    step();
    in_ins = mk(102, 5'd2);
    step();
    check("bp_ready_full", {127'd0, ready_o}, 128'd0);
    check("bp_hold_reg1", {96'd0, reg1_o}, 128'd100);
    step();
    check("bp_stall3", {112'd0, stall_cnt}, 128'd3);
    ready_i = 1'b1;
    step();
    check("bp_skid_reg1", {96'd0, reg1_o}, 128'd101);
    check("bp_ready_back", {127'd0, ready_o}, 128'd1);
    step();
    check("bp_last_reg1", {96'd0, reg1_o}, 128'd102);
    valid_i = 1'b0;
    step();
    check("bp_stall_keep", {112'd0, stall_cnt}, 128'd3);

    // flush in FULL with a wr_addr 9 instruction offered
    ready_i = 1'b0;
    valid_i = 1'b1;
    in_ins = mk(200, 5'd4);
    step();
    in_ins = mk(201, 5'd4);
    step();
    in_ins = mk(202, 5'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", {127'd0, valid_o}, 128'd0);
    check("fl_we", {127'd0, we_o}, 128'd0);
    check("fl_ready", {127'd0, ready_o}, 128'd1);
    check("fl_stall", {112'd0, stall_cnt}, 128'd5);
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    check("fl_nothing", {127'd0, valid_o}, 128'd0);
    valid_i = 1'b1;
    in_ins = mk(203, 5'd12);
    step();
    check("fl_next_wa", {123'd0, wr_addr_o}, 128'd12);
    valid_i = 1'b0;
    step();

    // flush while BUSY drops the offered instruction even though ready_o=1
    valid_i = 1'b1;
    in_ins = mk(300, 5'd6);
    step();
    in_ins = mk(301, 5'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid_i = 1'b0;
    check("flb_valid", {127'd0, valid_o}, 128'd0);

    // mixed traffic, model-checked each cycle
    for (int i = 0; i < 60; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      in_ins = mk(400 + i, 5'(i));
      step();
    end
    flush = 1'b0;

    // reset mid-stall
    ready_i = 1'b0;
    valid_i = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    valid_i = 1'b0;
    check("rst_mid_valid", {127'd0, valid_o}, 128'd0);
    check("rst_mid_stall", {112'd0, stall_cnt}, 128'd0);
    ready_i = 1'b1;

    // saturation on the 4-bit counter
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("sat_14", {124'd0, s_cnt}, 128'd14);
    end
    check("sat_15", {124'd0, s_cnt}, 128'd15);
    check("sat_valid", {127'd0, s_valid_o}, 128'd1);

    // wide payload bit-exact
    w_valid = 1'b1;
    w_reg1 = 64'hDEAD_BEEF_0123_4567;
    w_reg2 = 64'h8000_0000_0000_0001;
    w_wa = 6'h2A;
    step();
    w_valid = 1'b0;
    check("wide_reg1", {64'd0, w_reg1_o}, {64'd0, 64'hDEAD_BEEF_0123_4567});
    check("wide_reg2", {64'd0, w_reg2_o}, {64'd0, 64'h8000_0000_0000_0001});
    check("wide_wa", {122'd0, w_wr_addr_o}, 128'h2A);
    step();
    check("wide_empty", {127'd0, w_valid_o}, 128'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
